// File: rtl/fir_stim_gen.sv
// fir_stim_gen: on-chip test-signal source for the FIR datapath.
// Produces sine, square, sawtooth or LFSR-noise samples at a programmable
// sample rate, scales them by an unsigned gain with saturation and presents
// them on a valid/ready output. Usable in hardware as a built-in self-test
// stimulus.
module fir_stim_gen #(
    parameter int DATA_W     = 16,
    parameter int PHASE_W    = 24,
    parameter int LUT_ADDR_W = 8,
    parameter int DIV_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic [PHASE_W-1:0]       phase_inc,
    input  logic [DATA_W-1:0]        amplitude,
    input  logic [DIV_W-1:0]         div,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun,
    output logic [31:0]              sample_count
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int  LUT_DEPTH = 1 << LUT_ADDR_W;
    localparam int  PROD_W    = 2 * DATA_W + 1;
    localparam int  SINE_PEAK = (1 << (DATA_W - 1)) - 1;
    localparam real PI        = 3.14159265358979323846;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    // Square wave is symmetric: +peak / -peak, never the most negative code.
    localparam logic signed [DATA_W-1:0] SQ_POS  = SAT_MAX;
    localparam logic signed [DATA_W-1:0] SQ_NEG  = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

    localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // One sine table entry, round(peak * sin(2*pi*idx/depth)).
    // The angle is folded into the first quadrant so the Taylor series
    // only ever sees [0, pi/2], where 13 terms are far below one LSB of
    // error. Rounding is done on the magnitude, giving round-half-away
    // behaviour that is symmetric for negative entries.
    function automatic logic signed [DATA_W-1:0] sine_entry(input int idx);
        int   half_s;
        int   quarter_s;
        int   k_s;
        int   mag_s;
        logic neg_s;
        real  x_s;
        real  term_s;
        real  sum_s;
        half_s    = LUT_DEPTH / 2;
        quarter_s = LUT_DEPTH / 4;
        neg_s     = (idx >= half_s);
        k_s       = neg_s ? (idx - half_s) : idx;
        if (k_s > quarter_s) begin
            k_s = half_s - k_s;
        end
        x_s    = 2.0 * PI * $itor(k_s) / $itor(LUT_DEPTH);
        term_s = x_s;
        sum_s  = x_s;
        for (int n = 1; n < 14; n++) begin
            term_s = -term_s * x_s * x_s / $itor((2 * n) * (2 * n + 1));
            sum_s  = sum_s + term_s;
        end
        mag_s = $rtoi(sum_s * $itor(SINE_PEAK) + 0.5);
        if (mag_s > SINE_PEAK) begin
            mag_s = SINE_PEAK;
        end
        if (neg_s) begin
            return DATA_W'(-mag_s);
        end else begin
            return DATA_W'(mag_s);
        end
    endfunction

    // Right-shift Galois LFSR step.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0000_0000);
    endfunction

    // ------------------------------------------------------------------
    // Sine lookup table, fixed at elaboration
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] sine_lut_s [LUT_DEPTH];

    for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_sine_lut
        localparam logic signed [DATA_W-1:0] ENTRY = sine_entry(gi);
        assign sine_lut_s[gi] = ENTRY;
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]         div_cnt_r;
    logic [PHASE_W-1:0]       phase_r;
    logic [31:0]              lfsr_r;
    logic                     s1_valid_r;
    logic signed [DATA_W-1:0] s1_raw_r;
    logic [DATA_W-1:0]        s1_amp_r;

    // ------------------------------------------------------------------
    // Handshake / control
    // ------------------------------------------------------------------
    logic tick_s;
    logic stall_s;
    logic s1_load_s;
    logic drop_s;

    assign tick_s    = enable & (div_cnt_r == div);
    assign stall_s   = out_valid & ~out_ready;
    // Stage 1 can take a new sample if it is empty or is being drained now.
    assign s1_load_s = tick_s & (~s1_valid_r | ~stall_s);
    assign drop_s    = tick_s & s1_valid_r & stall_s;

    // ------------------------------------------------------------------
    // Raw waveform selection
    // ------------------------------------------------------------------
    logic [LUT_ADDR_W-1:0]    lut_addr_s;
    logic signed [DATA_W-1:0] raw_s;

    assign lut_addr_s = phase_r[PHASE_W-1 -: LUT_ADDR_W];

    // Select the un-scaled sample for the current phase and mode.
    always_comb begin
        raw_s = '0;
        case (mode)
            2'd0:    raw_s = sine_lut_s[lut_addr_s];
            2'd1:    raw_s = phase_r[PHASE_W-1] ? SQ_NEG : SQ_POS;
            2'd2:    raw_s = $signed(phase_r[PHASE_W-1 -: DATA_W]);
            2'd3:    raw_s = $signed(lfsr_r[DATA_W-1:0]);
            default: raw_s = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Amplitude scaling and saturation (feeds the output register)
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] shifted_s;
    logic signed [DATA_W-1:0] scaled_s;

    // Multiply by the unsigned gain, drop the unity scale with a flooring
    // arithmetic shift, then clamp back into the output range.
    always_comb begin
        prod_s    = PROD_W'(s1_raw_r) * PROD_W'($signed({1'b0, s1_amp_r}));
        shifted_s = prod_s >>> (DATA_W - 1);
        if (shifted_s > PROD_W'(SAT_MAX)) begin
            scaled_s = SAT_MAX;
        end else if (shifted_s < PROD_W'(SAT_MIN)) begin
            scaled_s = SAT_MIN;
        end else begin
            scaled_s = shifted_s[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Sample-rate divider: counts 0..div while enabled, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_r <= '0;
        end else if (!enable) begin
            div_cnt_r <= '0;
        end else if (div_cnt_r >= div) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Stage 1: capture raw sample and gain on an accepted tick; phase and
    // LFSR advance only then, so a dropped tick leaves the waveform intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_raw_r   <= '0;
            s1_amp_r   <= '0;
            phase_r    <= '0;
            lfsr_r     <= LFSR_SEED;
        end else if (s1_load_s) begin
            s1_valid_r <= 1'b1;
            s1_raw_r   <= raw_s;
            s1_amp_r   <= amplitude;
            phase_r    <= phase_r + phase_inc;
            lfsr_r     <= lfsr_next(lfsr_r);
        end else if (!stall_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Sticky overrun flag: set whenever a tick finds no room in the pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop_s) begin
            overrun <= 1'b1;
        end else begin
            overrun <= overrun;
        end
    end

    // Stage 2 / output register: advances unless the consumer is stalling.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!stall_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_data <= scaled_s;
            end else begin
                out_data <= out_data;
            end
        end else begin
            out_valid <= out_valid;
            out_data  <= out_data;
        end
    end

    // Count samples handed to the consumer; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_count <= '0;
        end else if (out_valid && out_ready) begin
            sample_count <= sample_count + 32'd1;
        end else begin
            sample_count <= sample_count;
        end
    end

endmodule

// File: tb/tb_fir_stim_gen.sv
// Directed self-checking bench for fir_stim_gen.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_fir_stim_gen;

    localparam int DATA_W     = 16;
    localparam int PHASE_W    = 24;
    localparam int LUT_ADDR_W = 8;
    localparam int DIV_W      = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     enable;
    logic [1:0]               mode;
    logic [PHASE_W-1:0]       phase_inc;
    logic [DATA_W-1:0]        amplitude;
    logic [DIV_W-1:0]         div;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     overrun;
    logic [31:0]              sample_count;

    int n_checks = 0;
    int n_fail   = 0;

    fir_stim_gen #(
        .DATA_W     (DATA_W),
        .PHASE_W    (PHASE_W),
        .LUT_ADDR_W (LUT_ADDR_W),
        .DIV_W      (DIV_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mode         (mode),
        .phase_inc    (phase_inc),
        .amplitude    (amplitude),
        .div          (div),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    // Hand-computed sine stream for phase_inc=0x400000, amplitude=32767.
    function automatic logic signed [15:0] sine_exp(input int k);
        case (k % 4)
            0:       return 16'sd0;
            1:       return 16'sd32766;
            2:       return 16'sd0;
            default: return -16'sd32767;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_data !== 16'sd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", out_data); end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++;
        if (sample_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", sample_count); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL disabled_idle: got %b expected 0", out_valid); end
        end
    endtask

    task automatic test_sine();
        do_reset();
        mode = 2'd0; phase_inc = 24'h400000; amplitude = 16'd32767; div = 16'd0; enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sine_latency: got valid %b expected 0", out_valid); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== sine_exp(i)) begin
                n_fail++; $display("FAIL sine_sample%0d: got %b/%0d expected 1/%0d", i, out_valid, out_data, sine_exp(i));
            end
            n_checks++;
            if (sample_count !== 32'(i)) begin n_fail++; $display("FAIL sine_count%0d: got %0d expected %0d", i, sample_count, i); end
        end
    endtask

    task automatic test_square();
        logic signed [15:0] exp_d;
        do_reset();
        mode = 2'd1; phase_inc = 24'h200000; amplitude = 16'd16384; div = 16'd0; enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_d = ((i % 8) < 4) ? 16'sd16383 : -16'sd16384;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d) begin
                n_fail++; $display("FAIL square_sample%0d: got %b/%0d expected 1/%0d", i, out_valid, out_data, exp_d);
            end
        end
    endtask

    task automatic test_backpressure();
        int                 acc;
        logic signed [15:0] held_d;
        logic               held_v;
        acc = 0; held_d = '0; held_v = 1'b0;
        do_reset();
        mode = 2'd0; phase_inc = 24'h400000; amplitude = 16'd32767; div = 16'd0; enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c < 9);
            n_checks++;
            if (sample_count !== 32'(acc)) begin n_fail++; $display("FAIL bp_count_c%0d: got %0d expected %0d", c, sample_count, acc); end
            if (c == 3) begin
                n_checks++;
                if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_overrun_early: got %b expected 0", overrun); end
            end
            if (c == 4) begin
                held_d = out_data; held_v = out_valid;
                n_checks++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_valid: got %b expected 1", out_valid); end
            end else if (c > 4 && c < 9) begin
                n_checks++;
                if (out_valid !== held_v || out_data !== held_d) begin
                    n_fail++; $display("FAIL bp_hold_c%0d: got %b/%0d expected %b/%0d", c, out_valid, out_data, held_v, held_d);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_data !== sine_exp(acc)) begin n_fail++; $display("FAIL bp_seq%0d: got %0d expected %0d", acc, out_data, sine_exp(acc)); end
                acc++;
            end
        end
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
        n_checks++;
        if (acc != 14) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 14", acc); end
    endtask

    task automatic test_divider();
        int   acc;
        logic exp_v;
        acc = 0;
        do_reset();
        mode = 2'd1; phase_inc = 24'h200000; amplitude = 16'd16384; div = 16'd9; enable = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            exp_v = (n >= 11) && (((n - 11) % 10) == 0);
            n_checks++;
            if (out_valid !== exp_v) begin n_fail++; $display("FAIL div_valid_n%0d: got %b expected %b", n, out_valid, exp_v); end
            n_checks++;
            if (sample_count !== 32'(acc)) begin n_fail++; $display("FAIL div_count_n%0d: got %0d expected %0d", n, sample_count, acc); end
            if (n == 11) begin
                n_checks++;
                if (out_data !== 16'sd16383) begin n_fail++; $display("FAIL div_data: got %0d expected 16383", out_data); end
            end
            if (exp_v) acc++;
        end
        @(negedge clk);
        n_checks++;
        if (sample_count !== 32'd4) begin n_fail++; $display("FAIL div_total: got %0d expected 4", sample_count); end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL div_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_lfsr();
        logic [31:0] model;
        model = 32'hFFFF_FFFF;
        do_reset();
        mode = 2'd3; phase_inc = 24'h000001; amplitude = 16'h8000; div = 16'd0; enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if (out_data !== 16'shFFFF) begin n_fail++; $display("FAIL lfsr_first: got %h expected ffff", out_data); end
            end
            if (i == 1) begin
                n_checks++;
                if (out_data !== 16'shFFFC) begin n_fail++; $display("FAIL lfsr_second: got %h expected fffc", out_data); end
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== model[15:0]) begin
                n_fail++; $display("FAIL lfsr_sample%0d: got %b/%h expected 1/%h", i, out_valid, out_data, model[15:0]);
            end
            model = (model >> 1) ^ (model[0] ? 32'h8020_0003 : 32'h0000_0000);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mode = 2'd2; phase_inc = 24'h800000; amplitude = 16'hFFFF; div = 16'd0; enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'sd0) begin n_fail++; $display("FAIL sat_a0: got %b/%0d expected 1/0", out_valid, out_data); end
        @(negedge clk);
        n_checks++;
        if (out_data !== 16'sh8000) begin n_fail++; $display("FAIL sat_a1: got %0d expected -32768", out_data); end

        do_reset();
        mode = 2'd2; phase_inc = 24'h7FFF00; amplitude = 16'hFFFF; div = 16'd0; enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_data !== 16'sd0) begin n_fail++; $display("FAIL sat_b0: got %0d expected 0", out_data); end
        @(negedge clk);
        n_checks++;
        if (out_data !== 16'sd32767) begin n_fail++; $display("FAIL sat_b1: got %0d expected 32767", out_data); end
        @(negedge clk);
        n_checks++;
        if (out_data !== -16'sd4) begin n_fail++; $display("FAIL sat_b2_floor: got %0d expected -4", out_data); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        mode = 2'd2; phase_inc = 24'h800000; amplitude = 16'hFFFF; div = 16'd0; enable = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL mid_overrun_set: got %b expected 1", overrun); end
        reset     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'sd0) begin n_fail++; $display("FAIL mid_reset_out: got %b/%0d expected 0/0", out_valid, out_data); end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL mid_reset_overrun: got %b expected 0", overrun); end
        n_checks++;
        if (sample_count !== 32'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected 0", sample_count); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_restart_latency: got %b expected 0", out_valid); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'sd0) begin n_fail++; $display("FAIL mid_restart_first: got %b/%0d expected 1/0", out_valid, out_data); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 2'd0; phase_inc = '0;
        amplitude = '0; div = '0; out_ready = 1'b1;
        test_reset();
        test_sine();
        test_square();
        test_backpressure();
        test_divider();
        test_lfsr();
        test_saturation();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_stim_gen.md
Name: fir_stim_gen

Overview:
Synthesizable, parametrised test-signal generator that feeds the FIR datapath. It is the on-chip successor to the simulation-only sine stimulus. It produces sine, square, sawtooth or pseudo-random samples at a programmable sample rate, with amplitude scaling, saturation and a valid/ready output handshake. It sits directly in front of the FIR input and is usable on hardware for built-in self-test.

Parameters:
DATA_W, 16, output sample width (signed two's complement)
PHASE_W, 24, phase accumulator width
LUT_ADDR_W, 8, log2 of sine LUT depth; table covers one full period
DIV_W, 16, sample-rate divider width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  generator run enable
mode  in  2  0 sine, 1 square, 2 sawtooth, 3 LFSR noise
phase_inc  in  PHASE_W  phase step per sample (unsigned)
amplitude  in  DATA_W  unsigned gain; 2^(DATA_W-1) = unity
div  in  DIV_W  sample period minus 1, in clk cycles
out_data  out  DATA_W  signed sample
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts sample
overrun  out  1  sticky; a tick was dropped due to backpressure
sample_count  out  32  samples accepted (out_valid & out_ready), wraps at 2^32

Behaviour:
- Reset (clk edge with reset=1): out_data=0, out_valid=0, overrun=0, sample_count=0, phase=0, divider=0, LFSR=32'hFFFF_FFFF, pipeline valids=0. Reset overrides everything, including mid-stream operation; any in-flight samples are discarded.
- Divider: when enable=1, the counter runs 0..div and tick=1 in cycles where counter==div, then the counter wraps to 0. div=0 gives a tick every cycle. When enable=0, the counter is held at 0, no ticks occur, and in-flight samples still drain.
- Pipeline: 2 stages. stall = out_valid & !out_ready.
  - Stage 1 loads on a tick when stage 1 is empty or !stall.
  - Stage 2 (the output register) loads from stage 1 when !stall.
  - Tick accepted in cycle T: out_valid=1 from cycle T+2 when no stall occurs.
  - Full rate (div=0, out_ready=1) gives one sample per cycle.
- Dropped tick: a tick in a cycle with stage 1 full and stall=1 is dropped. overrun is set to 1 and stays set until reset. On a dropped tick, phase and LFSR do not advance and no sample is produced.
- Accepted tick:
  - Stage 1 captures raw(phase) using the current mode.
  - phase <= phase + phase_inc, modulo 2^PHASE_W.
  - The LFSR advances once.
  - mode, phase_inc and amplitude are sampled at that tick.
  - The first sample after reset uses phase=0.
- raw definitions (p = phase[PHASE_W-1 -: LUT_ADDR_W]):
  - sine: LUT[p] = round((2^(DATA_W-1)-1)*sin(2*pi*p/2^LUT_ADDR_W)). Contents are generated at elaboration by a constant function.
  - square: phase MSB=0 gives +(2^(DATA_W-1)-1); MSB=1 gives -(2^(DATA_W-1)-1).
  - sawtooth: phase[PHASE_W-1 -: DATA_W] interpreted as signed.
  - LFSR: low DATA_W bits of a 32-bit right-shift Galois LFSR, mask 32'h80200003. Next state = (s>>1) ^ (s[0] ? mask : 0).
- Scaling in stage 2: prod = raw * amplitude, signed by zero-extended unsigned, 2*DATA_W+1 bits. shifted = prod >>> (DATA_W-1) (arithmetic, floor). out_data = shifted clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Output hold: while stall=1, out_data and out_valid are held stable.
- sample_count increments in each cycle with out_valid & out_ready.

Test Plan:
1. Sine: reset, mode=0, phase_inc=24'h400000, amplitude=32767, div=0, out_ready=1, enable=1 → out_data repeats 0, 32766, 0, -32767. First out_valid arrives 2 cycles after the first tick; sample_count = 4 after 4 valid cycles.
2. Square: mode=1, phase_inc=24'h200000, amplitude=16384 → 16383 ×4, then -16384 ×4, repeating.
3. Backpressure: steady sine stream; hold out_ready=0 for 5 cycles → out_data/out_valid held constant, overrun=1, sample_count frozen. After release, output phases continue with no skip or duplicate, because phase advances only on accepted ticks.
4. Divider: div=9, out_ready=1 → exactly one out_valid pulse per 10 cycles; sample_count increments once every 10 cycles; overrun stays 0.
5. LFSR: mode=3, amplitude=32768 (unity) → first samples are -1 (0xFFFF), then -4 (0xFFFC), matching a reference-model LFSR for 1000 samples.
6. Saturation and reset: mode=2, amplitude=65535.
   - phase_inc=24'h800000 → 0, -32768 (clamped).
   - phase_inc=24'h7FFF00 → second sample is 32767 (clamped).
   - Assert reset mid-stream → next cycle out_valid=0, out_data=0, overrun=0, sample_count=0; first sample after release is 0.
